// File: rtl/key_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_event_ctrl_if
//   Avalon-MM bus between key_event_ctrl (master) and the 4-bit key PIO
//   (slave). It also carries the PIO level interrupt back to the master.
//
//   pio_address     master->slave  2   register address (2 = irq_mask, 3 = edge_capture)
//   pio_chipselect  master->slave  1   single-cycle access strobe
//   pio_write_n     master->slave  1   active-low write strobe
//   pio_writedata   master->slave  32  write data
//   pio_readdata    slave->master  32  read data, valid one cycle after the read access
//   pio_irq         slave->master  1   level interrupt
// -----------------------------------------------------------------------------
interface key_event_ctrl_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;

  modport master (
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata,
    input  pio_readdata,
    input  pio_irq
  );

  modport slave (
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata,
    output pio_readdata,
    output pio_irq
  );
endinterface

// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
//   Avalon-MM master that owns the key PIO. After reset it programs the PIO
//   irq_mask; on each PIO interrupt it reads edge_capture, clears it and queues
//   the captured key vector into an event FIFO for the application logic.
//   Mask updates requested by the consumer are applied between capture
//   sequences.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   pio (master modport)    Avalon-MM bus + irq to the key PIO
//   cfg_mask, cfg_mask_wr   new irq_mask value and its 1-cycle request pulse
//   evt_valid, evt_key      FIFO not empty / head-of-FIFO key vector
//   evt_ready               consumer pop (taken when evt_valid && evt_ready)
//   overflow, ovf_clr       sticky event-dropped flag and its clear
//   busy                    FSM is not in IDLE
//   evt_time                head entry timestamp (only with the macro below)
//
// Build option
//   KEY_EVENT_CTRL_TIMESTAMP_EN: adds a 16-bit free-running cycle counter,
//   latched in WAIT and stored with every FIFO entry; exposed as evt_time.
//
// FIFO_DEPTH must be a power of 2 and at least 2.
// -----------------------------------------------------------------------------
module key_event_ctrl #(
  parameter int              KEY_W      = 4,
  parameter logic [KEY_W-1:0] MASK_INIT = KEY_W'(4'hF),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  key_event_ctrl_if.master pio,
  input  logic [KEY_W-1:0] cfg_mask,
  input  logic             cfg_mask_wr,
  output logic             evt_valid,
  output logic [KEY_W-1:0] evt_key,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  ,
  output logic [15:0]      evt_time
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  localparam int ENT_W = KEY_W + 16;
`else
  localparam int ENT_W = KEY_W;
`endif

  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MASK,
    S_RD,
    S_WAIT,
    S_CLR,
    S_PUSH
  } state_e;

  state_e state_q, state_d;

  // Registered bus outputs
  logic [1:0]  pio_address_q, pio_address_d;
  logic        pio_chipselect_q, pio_chipselect_d;
  logic        pio_write_n_q, pio_write_n_d;
  logic [31:0] pio_writedata_q, pio_writedata_d;

  // Capture and pending-mask state
  logic [KEY_W-1:0] cap_q, cap_d;
  logic             pend_q, pend_d;
  logic [KEY_W-1:0] mask_pend_q, mask_pend_d;

  // Event FIFO
  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic             fifo_full;
  logic             do_push;
  logic             do_pop;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head_entry;

`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_cnt_d;
  logic [15:0] ts_cap_q, ts_cap_d;
`endif

  // Only the key bits of the PIO read data carry information.
  logic unused_rd_hi;
  assign unused_rd_hi = ^pio.pio_readdata[31:KEY_W];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        // A pending mask update is serviced before a new capture.
        if (pend_q) begin
          state_d = S_MASK;
        end else if (pio.pio_irq) begin
          state_d = S_RD;
        end
      end
      S_MASK: state_d = S_IDLE;
      S_RD:   state_d = S_WAIT;
      S_WAIT: state_d = S_CLR;
      S_CLR:  state_d = S_PUSH;
      S_PUSH: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // The bus registers are loaded on the edge that enters a state, so the
  // access is visible on the bus while the FSM is in that state. The INIT
  // write is the exception: INIT is the reset state, so its write is loaded
  // on the edge that leaves it.
  // ---------------------------------------------------------------------------
  always_comb begin
    pio_chipselect_d = 1'b0;
    pio_write_n_d    = 1'b1;
    pio_address_d    = 2'd0;
    pio_writedata_d  = 32'd0;
    busy             = (state_q != S_IDLE);
    push_req         = (state_q == S_PUSH) && (cap_q != '0);

    if (state_q == S_INIT) begin
      pio_chipselect_d = 1'b1;
      pio_write_n_d    = 1'b0;
      pio_address_d    = ADDR_MASK;
      pio_writedata_d  = 32'(MASK_INIT);
    end else begin
      unique case (state_d)
        S_MASK: begin
          pio_chipselect_d = 1'b1;
          pio_write_n_d    = 1'b0;
          pio_address_d    = ADDR_MASK;
          pio_writedata_d  = 32'(mask_pend_q);
        end
        S_RD: begin
          pio_chipselect_d = 1'b1;
          pio_address_d    = ADDR_EDGE;
        end
        S_CLR: begin
          // cap_d already holds the value sampled in WAIT.
          pio_chipselect_d = 1'b1;
          pio_write_n_d    = 1'b0;
          pio_address_d    = ADDR_EDGE;
          pio_writedata_d  = 32'(cap_d);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture, pending mask, timestamp
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_d       = cap_q;
    pend_d      = pend_q;
    mask_pend_d = mask_pend_q;

    if (state_q == S_WAIT) begin
      cap_d = pio.pio_readdata[KEY_W-1:0];
    end

    // The pending value is consumed when MASK is entered; a request in the
    // same cycle re-arms it with the newer value.
    if (state_q == S_IDLE && state_d == S_MASK) begin
      pend_d = 1'b0;
    end
    if (cfg_mask_wr) begin
      pend_d      = 1'b1;
      mask_pend_d = cfg_mask;
    end
  end

`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  always_comb begin
    ts_cnt_d = ts_cnt_q + 16'd1;
    ts_cap_d = (state_q == S_WAIT) ? ts_cnt_q : ts_cap_q;
  end
  assign push_entry = {ts_cap_q, cap_q};
`else
  assign push_entry = cap_q;
`endif

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  assign head_entry = fifo_mem_q[rd_ptr_q];
  assign evt_valid  = (count_q != '0);
  assign evt_key    = head_entry[KEY_W-1:0];
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  assign evt_time   = head_entry[KEY_W +: 16];
`endif
  assign overflow   = overflow_q;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop    = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push_req && (!fifo_full || do_pop);

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (do_push) begin
      fifo_mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear.
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (push_req && !do_push) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and bus registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_address_q    <= 2'd0;
      pio_chipselect_q <= 1'b0;
      pio_write_n_q    <= 1'b1;
      pio_writedata_q  <= 32'd0;
      cap_q            <= '0;
      pend_q           <= 1'b0;
      mask_pend_q      <= '0;
      fifo_mem_q       <= '{default: '0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      overflow_q       <= 1'b0;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
      ts_cnt_q         <= 16'd0;
      ts_cap_q         <= 16'd0;
`endif
    end else begin
      pio_address_q    <= pio_address_d;
      pio_chipselect_q <= pio_chipselect_d;
      pio_write_n_q    <= pio_write_n_d;
      pio_writedata_q  <= pio_writedata_d;
      cap_q            <= cap_d;
      pend_q           <= pend_d;
      mask_pend_q      <= mask_pend_d;
      fifo_mem_q       <= fifo_mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      overflow_q       <= overflow_d;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
      ts_cnt_q         <= ts_cnt_d;
      ts_cap_q         <= ts_cap_d;
`endif
    end
  end

  assign pio.pio_address    = pio_address_q;
  assign pio.pio_chipselect = pio_chipselect_q;
  assign pio.pio_write_n    = pio_write_n_q;
  assign pio.pio_writedata  = pio_writedata_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_event_ctrl
//   Bench for key_event_ctrl with a behavioural key PIO (edge_capture,
//   irq_mask, level irq) and a scoreboard of expected FIFO events.
// -----------------------------------------------------------------------------
module tb_key_event_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] cfg_mask;
  logic       cfg_mask_wr;
  logic       evt_valid;
  logic [3:0] evt_key;
  logic       evt_ready;
  logic       overflow;
  logic       ovf_clr;
  logic       busy;
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
  logic [15:0] evt_time;
`endif

  key_event_ctrl_if pio ();

  key_event_ctrl #(
    .KEY_W      (4),
    .MASK_INIT  (4'hF),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pio         (pio),
    .cfg_mask    (cfg_mask),
    .cfg_mask_wr (cfg_mask_wr),
    .evt_valid   (evt_valid),
    .evt_key     (evt_key),
    .evt_ready   (evt_ready),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .busy        (busy)
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
    ,
    .evt_time    (evt_time)
`endif
  );

  // ---------------------------------------------------------------------------
  // Behavioural key PIO
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [3:0] data;
  } acc_t;

  acc_t       acc_log [$];
  logic [3:0] edge_m;
  logic [3:0] mask_m;
  logic [3:0] inject;
  logic       cs_prev;
  int         cs_run_err = 0;
  int         hi_err     = 0;
  logic [15:0] tsm;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_m           <= 4'h0;
      mask_m           <= 4'h0;
      cs_prev          <= 1'b0;
      pio.pio_readdata <= 32'hA5A5_A5A5;
    end else begin
      cs_prev          <= pio.pio_chipselect;
      pio.pio_readdata <= 32'hA5A5_A5A5;
      edge_m           <= edge_m | inject;
      if (pio.pio_chipselect && cs_prev) cs_run_err <= cs_run_err + 1;
      if (pio.pio_chipselect) begin
        acc_log.push_back({!pio.pio_write_n, pio.pio_address, pio.pio_writedata[3:0]});
        if (pio.pio_writedata[31:4] != 28'd0) hi_err <= hi_err + 1;
        if (!pio.pio_write_n && pio.pio_address == 2'd2) mask_m <= pio.pio_writedata[3:0];
        if (!pio.pio_write_n && pio.pio_address == 2'd3) edge_m <= inject;
        if (pio.pio_write_n && pio.pio_address == 2'd3) pio.pio_readdata <= {28'd0, edge_m};
      end
    end
  end

  assign pio.pio_irq = |(edge_m & mask_m);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tsm <= 16'd0;
    else          tsm <= tsm + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  key;
    logic [15:0] t;
  } exp_t;

  exp_t sb_q [$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns one cycle later with the edge latched
  // in the PIO. ts_off is the distance from now to the WAIT cycle.
  task automatic inject_evt(input logic [3:0] bits, input bit keep, input int ts_off);
    exp_t e;
    inject = bits;
    if (keep) begin
      e.key = bits;
      e.t   = 16'(int'(tsm) + ts_off);
      sb_q.push_back(e);
    end
    @(negedge clk);
    inject = 4'h0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 20; n++) begin
      if (!busy && !pio.pio_irq) break;
      @(negedge clk);
    end
    check_val(tag, 32'(n < 20), 32'd1);
  endtask

  task automatic pop_one(input string tag);
    int   n;
    exp_t e;
    for (n = 0; n < 10; n++) begin
      if (evt_valid) break;
      @(negedge clk);
    end
    if (!evt_valid) begin
      check_val({tag, "_valid"}, 32'(evt_valid), 32'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_key"}, 32'(evt_key), 32'(e.key));
`ifdef KEY_EVENT_CTRL_TIMESTAMP_EN
      check_val({tag, "_time"}, 32'(evt_time), 32'(e.t));
`endif
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (sb_q.size() != 0) pop_one(tag);
    check_val({tag, "_empty"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] ov_keys [5];
    acc_t       exp_log [5];
    int         lat;

    reset_n     = 1'b0;
    inject      = 4'h0;
    cfg_mask    = 4'h0;
    cfg_mask_wr = 1'b0;
    evt_ready   = 1'b0;
    ovf_clr     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_cs",     32'(pio.pio_chipselect), 32'd0);
    check_val("rst_wr_n",   32'(pio.pio_write_n),    32'd1);
    check_val("rst_addr",   32'(pio.pio_address),    32'd0);
    check_val("rst_wdata",  pio.pio_writedata,       32'd0);
    check_val("rst_valid",  32'(evt_valid),          32'd0);
    check_val("rst_key",    32'(evt_key),            32'd0);
    check_val("rst_ovf",    32'(overflow),           32'd0);
    check_val("rst_busy",   32'(busy),               32'd1);

    // Mask programming right after reset release
    reset_n = 1'b1;
    @(negedge clk);
    check_val("init_cs",    32'(pio.pio_chipselect), 32'd1);
    check_val("init_wr_n",  32'(pio.pio_write_n),    32'd0);
    check_val("init_addr",  32'(pio.pio_address),    32'd2);
    check_val("init_wdata", pio.pio_writedata,       32'h0000_000F);
    @(negedge clk);
    check_val("init_busy",  32'(busy),               32'd0);
    check_val("init_cs_lo", 32'(pio.pio_chipselect), 32'd0);

    // Single event: latency and clear write
    acc_log.delete();
    inject_evt(4'h4, 1'b1, 3);
    for (lat = 1; lat <= 5; lat++) begin
      @(negedge clk);
      if (evt_valid) break;
    end
    check_val("irq_latency", 32'(evt_valid), 32'd1);
    check_val("irq_nacc",    32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      check_val("irq_rd",  32'(acc_log[0]), 32'({1'b0, 2'd3, 4'h0}));
      check_val("irq_clr", 32'(acc_log[1]), 32'({1'b1, 2'd3, 4'h4}));
    end
    drain("single");

    // Overflow: five events with no consumer, depth 4
    ov_keys = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
    for (int k = 0; k < 5; k++) begin
      inject_evt(ov_keys[k], k < 4, 3);
      wait_idle("ovf_idle");
      if (k == 3) check_val("ovf_before", 32'(overflow), 32'd0);
    end
    check_val("ovf_set", 32'(overflow), 32'd1);
    drain("ovf");
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("ovf_clr", 32'(overflow), 32'd0);

    // Mask requests during a capture; irq stays high afterwards
    acc_log.delete();
    inject_evt(4'h2, 1'b1, 3);   // IDLE with irq
    @(negedge clk);              // RD
    @(negedge clk);              // WAIT
    cfg_mask    = 4'h5;
    cfg_mask_wr = 1'b1;
    @(negedge clk);              // CLR
    cfg_mask    = 4'h6;
    @(negedge clk);              // PUSH
    cfg_mask_wr = 1'b0;
    inject_evt(4'h4, 1'b1, 5);
    wait_idle("mask_idle");
    exp_log = '{{1'b0, 2'd3, 4'h0}, {1'b1, 2'd3, 4'h2}, {1'b1, 2'd2, 4'h6},
                {1'b0, 2'd3, 4'h0}, {1'b1, 2'd3, 4'h4}};
    check_val("mask_nacc", 32'(acc_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < acc_log.size()) check_val("mask_seq", 32'(acc_log[k]), 32'(exp_log[k]));
    end
    drain("mask");
    cfg_mask    = 4'hF;
    cfg_mask_wr = 1'b1;
    @(negedge clk);
    cfg_mask_wr = 1'b0;
    @(negedge clk);
    wait_idle("mask_restore_idle");
    check_val("mask_restore", 32'(mask_m), 32'hF);

    // Full FIFO with push and pop in the same cycle
    for (int k = 0; k < 4; k++) begin
      inject_evt(ov_keys[k], 1'b1, 3);
      wait_idle("full_idle");
    end
    inject_evt(4'h9, 1'b1, 3);   // IDLE with irq
    repeat (4) @(negedge clk);   // PUSH
    pop_one("full_pp");
    check_val("full_pp_ovf",   32'(overflow),  32'd0);
    check_val("full_pp_valid", 32'(evt_valid), 32'd1);
    drain("full");

    // Pop while empty is ignored
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    evt_ready = 1'b0;
    check_val("empty_pop", 32'(evt_valid), 32'd0);
    inject_evt(4'h1, 1'b1, 3);
    wait_idle("empty_idle");
    drain("empty");

    // Reset in the middle of a read access
    inject_evt(4'h8, 1'b0, 0);
    @(negedge clk);
    check_val("mid_rd_cs", 32'(pio.pio_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_cs",   32'(pio.pio_chipselect), 32'd0);
    check_val("mid_rst_busy", 32'(busy),               32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("mid_init_cs",   32'(pio.pio_chipselect), 32'd1);
    check_val("mid_init_addr", 32'(pio.pio_address),    32'd2);
    @(negedge clk);
    wait_idle("mid_idle");
    check_val("mid_valid", 32'(evt_valid), 32'd0);

    // Bus protocol invariants over the whole run
    check_val("cs_single_cycle", 32'(cs_run_err), 32'd0);
    check_val("wdata_hi_zero",   32'(hi_err),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Avalon-MM master that owns the 4-bit key PIO slave (irq_mask at address 2, edge_capture at address 3).
- After reset, programs the PIO interrupt mask.
- On PIO irq: reads edge_capture, clears it, and queues the captured key vector into an event FIFO for the consumer (game/FSM logic).
- Applies runtime mask changes from the consumer.
- Sits between the PIO and the application logic, in place of a CPU polling loop.

Parameters:
KEY_W, 4, number of keys; width of mask and event vectors.
MASK_INIT, 4'hF, irq_mask value written after reset.
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pio_address  out  2  PIO register address
pio_chipselect  out  1  PIO select; single-cycle per access
pio_write_n  out  1  active-low write strobe
pio_writedata  out  32  PIO write data; bits above KEY_W are 0
pio_readdata  in  32  PIO read data; valid exactly 1 cycle after the read access cycle
pio_irq  in  1  PIO interrupt, level
cfg_mask  in  KEY_W  new irq_mask value
cfg_mask_wr  in  1  1-cycle pulse requesting a mask update
evt_valid  out  1  FIFO not empty
evt_key  out  KEY_W  head-of-FIFO captured key vector
evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready
overflow  out  1  sticky: event dropped because FIFO full
ovf_clr  in  1  clears overflow
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, evt_valid=0, evt_key=0, overflow=0, busy=1. FSM enters INIT. FIFO is emptied.
- Reset asserted mid-access: the access is aborted. The sequence restarts at INIT after release.
- All pio_* outputs are registered. Each access asserts chipselect for exactly 1 cycle.
- FSM states and transitions:
  - INIT: write MASK_INIT to address 2 (chipselect=1, write_n=0); next state IDLE.
  - IDLE: busy=0. If a mask write is pending, go to MASK; else if pio_irq=1, go to RD. A pending mask write has priority over irq.
  - MASK: write the latched mask to address 2; clear the pending flag; next state IDLE.
  - RD: read address 3 (chipselect=1, write_n=1); next state WAIT.
  - WAIT: chipselect=0; capture pio_readdata[KEY_W-1:0] into cap_reg; next state CLR.
  - CLR: write cap_reg to address 3. The PIO clears all edge_capture bits on any write to address 3. Next state PUSH.
  - PUSH: if cap_reg!=0, push cap_reg into the FIFO; next state IDLE.
- irq to IDLE timing: RD, WAIT, CLR, PUSH take 4 cycles. Worst-case event latency from irq (in IDLE) to evt_valid is 5 cycles.
- Edges captured between the WAIT sample and the CLR write are cleared and lost. This is an accepted limitation.
- cfg_mask_wr:
  - Latched into a pending register in any state.
  - A later pulse before service overwrites the pending mask value (last value wins).
  - A pulse in the same cycle that MASK clears the pending flag re-sets the flag with the new value.
- FIFO behaviour:
  - FIFO_DEPTH entries. Pointers are log2(FIFO_DEPTH) bits and wrap naturally; a separate count of log2(FIFO_DEPTH)+1 bits tracks occupancy.
  - evt_key shows the head entry combinationally from storage.
  - Push while full and no pop in the same cycle: the entry is dropped and overflow is set.
  - Push while full with a pop in the same cycle: the push is accepted and count is unchanged.
  - Pop while empty: ignored.
- overflow: ovf_clr and a new overflow in the same cycle leave overflow=1 (set wins).
- pio_irq falling while the FSM is in RD or WAIT: the sequence completes anyway. An all-zero capture is not pushed.

Optional Feature:
Macro KEY_EVENT_CTRL_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter (reset 0, wraps FFFF to 0000).
  - The counter value is latched in WAIT and stored with each FIFO entry.
  - Output port evt_time (out, 16) presents the head entry's timestamp; reset value 0.
- Undefined: no counter and no evt_time port. FIFO entries are KEY_W bits wide.

Test Plan:
- Reset release -> cycle 1: pio_address=2, write_n=0, writedata=0x0000000F, chipselect=1. Next cycle: busy=0.
- pio_irq=1 with pio_readdata=0x4 one cycle after RD -> CLR writes 0x4 to address 3. evt_valid=1, evt_key=4'b0100 within 5 cycles of irq.
- Five irq events (0x1, 0x2, 0x4, 0x8, 0x3) with evt_ready=0 and FIFO_DEPTH=4 -> the 0x3 event is dropped and overflow=1. Pops return 1, 2, 4, 8. ovf_clr -> overflow=0.
- cfg_mask_wr pulses 0x5 then 0x6 while the FSM is in WAIT, with irq still high -> the capture sequence finishes; then MASK writes 0x6 to address 2 (one write) before the next RD.
- FIFO full, push and pop in the same cycle -> the push is accepted, count stays 4, overflow stays 0.
- With the macro defined: irq at counter 0x0010 -> evt_time=0x0012, the WAIT-cycle value.
